// File: rtl/mat_loop_ctrl.sv
// Three-level (row, column, depth) loop sequencer feeding the MAC stage one index triple per handshake.
// Optional abort input is enabled by defining MAT_LOOP_CTRL_ABORT_EN.
module mat_loop_ctrl #(
  parameter int IDX_WIDTH = 8
) (
  input  logic                 clkIn,
  input  logic                 rstIn,
  input  logic                 startIn,
  input  logic [IDX_WIDTH-1:0] rowsIn,
  input  logic [IDX_WIDTH-1:0] colsIn,
  input  logic [IDX_WIDTH-1:0] depthIn,
`ifdef MAT_LOOP_CTRL_ABORT_EN
  input  logic                 abortIn,
`endif
  output logic                 busyOut,
  output logic                 idxValidOut,
  input  logic                 idxReadyIn,
  output logic [IDX_WIDTH-1:0] rowIdxOut,
  output logic [IDX_WIDTH-1:0] colIdxOut,
  output logic [IDX_WIDTH-1:0] kIdxOut,
  output logic                 lastKOut,
  output logic                 doneOut
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ctrlState_e;

  localparam logic [IDX_WIDTH-1:0] IDX_ONE = IDX_WIDTH'(1);

  ctrlState_e           state;
  logic [IDX_WIDTH-1:0] rowsReg;
  logic [IDX_WIDTH-1:0] colsReg;
  logic [IDX_WIDTH-1:0] depthReg;

  logic abortReq;
  logic handshake;
  logic kLast;
  logic jLast;
  logic iLast;
  logic zeroDim;

`ifdef MAT_LOOP_CTRL_ABORT_EN
  assign abortReq = abortIn;
`else
  assign abortReq = 1'b0;
`endif

  // Equality against dimension-1 only; in RUN every dimension is >= 1, so no underflow matters.
  assign kLast     = (kIdxOut   == depthReg - IDX_ONE);
  assign jLast     = (colIdxOut == colsReg  - IDX_ONE);
  assign iLast     = (rowIdxOut == rowsReg  - IDX_ONE);
  assign handshake = idxValidOut & idxReadyIn;
  assign lastKOut  = idxValidOut & kLast;
  assign zeroDim   = (rowsIn == '0) || (colsIn == '0) || (depthIn == '0);

  // NOTE: all state and outputs here are flops, so only non-blocking assignments are used;
  // reset is sampled on the clock edge because the surrounding fabric uses synchronous reset.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state       <= IDLE;
      rowsReg     <= '0;
      colsReg     <= '0;
      depthReg    <= '0;
      rowIdxOut   <= '0;
      colIdxOut   <= '0;
      kIdxOut     <= '0;
      idxValidOut <= 1'b0;
      busyOut     <= 1'b0;
      doneOut     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          doneOut     <= 1'b0;
          busyOut     <= 1'b0;
          idxValidOut <= 1'b0;
          if (startIn) begin
            rowsReg   <= rowsIn;
            colsReg   <= colsIn;
            depthReg  <= depthIn;
            rowIdxOut <= '0;
            colIdxOut <= '0;
            kIdxOut   <= '0;
            busyOut   <= 1'b1;
            if (zeroDim) begin
              // Empty job: report completion without emitting any triple.
              state   <= DONE;
              doneOut <= 1'b1;
            end else begin
              state       <= RUN;
              idxValidOut <= 1'b1;
            end
          end
        end

        RUN: begin
          if (abortReq) begin
            state       <= IDLE;
            idxValidOut <= 1'b0;
            busyOut     <= 1'b0;
            rowIdxOut   <= '0;
            colIdxOut   <= '0;
            kIdxOut     <= '0;
          end else if (handshake) begin
            if (!kLast) begin
              kIdxOut <= kIdxOut + IDX_ONE;
            end else begin
              kIdxOut <= '0;
              if (!jLast) begin
                colIdxOut <= colIdxOut + IDX_ONE;
              end else begin
                colIdxOut <= '0;
                if (!iLast) begin
                  rowIdxOut <= rowIdxOut + IDX_ONE;
                end else begin
                  state       <= DONE;
                  idxValidOut <= 1'b0;
                  doneOut     <= 1'b1;
                end
              end
            end
          end
        end

        DONE: begin
          state       <= IDLE;
          doneOut     <= 1'b0;
          busyOut     <= 1'b0;
          idxValidOut <= 1'b0;
        end

        default: begin
          state       <= IDLE;
          doneOut     <= 1'b0;
          busyOut     <= 1'b0;
          idxValidOut <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat_loop_ctrl.sv
// Self-checking bench for mat_loop_ctrl: expected triples come from plain nested loops over (M, N, K).
// Abort scenarios are exercised when MAT_LOOP_CTRL_ABORT_EN is defined.
module tb_mat_loop_ctrl;

  localparam int W = 8;

  logic         clkIn = 1'b0;
  logic         rstIn;
  logic         startIn;
  logic [W-1:0] rowsIn;
  logic [W-1:0] colsIn;
  logic [W-1:0] depthIn;
  logic         abortIn;
  logic         busyOut;
  logic         idxValidOut;
  logic         idxReadyIn;
  logic [W-1:0] rowIdxOut;
  logic [W-1:0] colIdxOut;
  logic [W-1:0] kIdxOut;
  logic         lastKOut;
  logic         doneOut;

  int checks = 0;
  int errors = 0;

  mat_loop_ctrl #(.IDX_WIDTH(W)) dut (
    .clkIn      (clkIn),
    .rstIn      (rstIn),
    .startIn    (startIn),
    .rowsIn     (rowsIn),
    .colsIn     (colsIn),
    .depthIn    (depthIn),
`ifdef MAT_LOOP_CTRL_ABORT_EN
    .abortIn    (abortIn),
`endif
    .busyOut    (busyOut),
    .idxValidOut(idxValidOut),
    .idxReadyIn (idxReadyIn),
    .rowIdxOut  (rowIdxOut),
    .colIdxOut  (colIdxOut),
    .kIdxOut    (kIdxOut),
    .lastKOut   (lastKOut),
    .doneOut    (doneOut)
  );

  always #5 clkIn = ~clkIn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    check({tag, ".valid"}, 32'(idxValidOut), 32'd0);
    check({tag, ".busy"},  32'(busyOut),     32'd0);
    check({tag, ".done"},  32'(doneOut),     32'd0);
    check({tag, ".lastK"}, 32'(lastKOut),    32'd0);
  endtask

  // DONE cycle: one done pulse, then a start issued in that cycle must be ignored.
  task automatic doneCycle(input string tag);
    check({tag, ".doneValid"}, 32'(idxValidOut), 32'd0);
    check({tag, ".donePulse"}, 32'(doneOut),     32'd1);
    check({tag, ".doneBusy"},  32'(busyOut),     32'd1);
    startIn = 1'b1;
    rowsIn  = 8'd3;
    colsIn  = 8'd3;
    depthIn = 8'd3;
    tick();
    startIn = 1'b0;
    checkIdle({tag, ".after"});
  endtask

  // mode 0: ready held high, 1: toggling 1,0,1,0..., 2: random.
  // stopAfter >= 0 returns with the triple at that position presented and not yet accepted.
  task automatic runJob(input int m, input int n, input int k, input int mode,
                        input int stopAfter, input bit pokeStart, input string tag);
    int  q[$];
    int  hs;
    int  cyc;
    int  total;
    int  kk;
    bit  tog;
    bit  r;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++)
        for (int d = 0; d < k; d++)
          q.push_back((i << 16) | (j << 8) | d);
    total = q.size();

    rowsIn  = W'(m);
    colsIn  = W'(n);
    depthIn = W'(k);
    startIn = 1'b1;
    tick();
    startIn = 1'b0;

    if (total == 0) begin
      doneCycle(tag);
      return;
    end

    hs  = 0;
    cyc = 0;
    tog = 1'b1;
    while (q.size() > 0 && hs != stopAfter) begin
      kk = q[0] & 255;
      check({tag, ".valid"},  32'(idxValidOut), 32'd1);
      check({tag, ".busy"},   32'(busyOut),     32'd1);
      check({tag, ".done"},   32'(doneOut),     32'd0);
      check({tag, ".triple"}, {8'h00, rowIdxOut, colIdxOut, kIdxOut}, 32'(q[0]));
      check({tag, ".lastK"},  32'(lastKOut),    32'(kk == k - 1));
      case (mode)
        0:       r = 1'b1;
        1:       begin r = tog; tog = ~tog; end
        default: r = 1'($urandom_range(0, 1));
      endcase
      idxReadyIn = r;
      startIn    = pokeStart && (cyc == 1);
      if (startIn) begin
        rowsIn  = W'($urandom_range(1, 5));
        colsIn  = W'($urandom_range(1, 5));
        depthIn = W'($urandom_range(1, 5));
      end
      tick();
      startIn = 1'b0;
      cyc++;
      if (r) begin
        void'(q.pop_front());
        hs++;
      end
      if (cyc > 4 * total + 20) begin
        check({tag, ".timeout"}, 32'(cyc), 32'(4 * total + 20));
        return;
      end
    end
    if (hs == stopAfter) return;
    idxReadyIn = 1'b0;
    if (mode == 0) check({tag, ".cycles"}, 32'(cyc), 32'(total));
    check({tag, ".handshakes"}, 32'(hs), 32'(total));
    doneCycle(tag);
  endtask

  initial begin
    rstIn      = 1'b1;
    startIn    = 1'b0;
    rowsIn     = '0;
    colsIn     = '0;
    depthIn    = '0;
    abortIn    = 1'b0;
    idxReadyIn = 1'b0;
    tick();
    tick();
    checkIdle("reset");
    check("reset.idx", {8'h00, rowIdxOut, colIdxOut, kIdxOut}, 32'd0);
    rstIn = 1'b0;
    tick();

    runJob(2, 2, 3, 0, -1, 1'b0, "m2n2k3");
    runJob(1, 1, 4, 1, -1, 1'b0, "k4toggle");
    runJob(3, 0, 5, 0, -1, 1'b0, "zeroN");
    runJob(255, 1, 1, 0, -1, 1'b0, "rows255");
    runJob(2, 3, 2, 2, -1, 1'b1, "pokeStart");
    for (int t = 0; t < 6; t++)
      runJob(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
             int'($urandom_range(1, 4)), 2, -1, 1'b1, "random");

    // Reset at triple (0,1,1) of a 2x2x2 job.
    idxReadyIn = 1'b0;
    runJob(2, 2, 2, 0, 3, 1'b0, "rstMid");
    check("rstMid.at", {8'h00, rowIdxOut, colIdxOut, kIdxOut}, 32'h0000_0101);
    rstIn = 1'b1;
    tick();
    rstIn      = 1'b0;
    idxReadyIn = 1'b0;
    checkIdle("rstMid.post");
    check("rstMid.idx", {8'h00, rowIdxOut, colIdxOut, kIdxOut}, 32'd0);
    tick();
    checkIdle("rstMid.later");
    runJob(1, 2, 2, 0, -1, 1'b0, "afterRst");

`ifdef MAT_LOOP_CTRL_ABORT_EN
    runJob(2, 2, 2, 0, 3, 1'b0, "abortMid");
    abortIn = 1'b1;
    tick();
    abortIn    = 1'b0;
    idxReadyIn = 1'b0;
    checkIdle("abortMid.post");
    check("abortMid.idx", {8'h00, rowIdxOut, colIdxOut, kIdxOut}, 32'd0);
    tick();
    checkIdle("abortMid.later");

    // Abort coinciding with the final handshake suppresses done.
    runJob(1, 1, 2, 0, 1, 1'b0, "abortFinal");
    idxReadyIn = 1'b1;
    abortIn    = 1'b1;
    tick();
    abortIn    = 1'b0;
    idxReadyIn = 1'b0;
    checkIdle("abortFinal.post");
    tick();
    checkIdle("abortFinal.later");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
